// File: rtl/memory_stage.sv
// rtl/memory_stage.sv - MEM stage: bus load/store with timeout, upstream stall, MEM/WB register and result mux
module memory_stage #(
  parameter int          TIMEOUT  = 16,
  parameter logic [15:0] ERR_DATA = 16'hDEAD
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        regWriteM,
  input  logic        memWriteM,
  input  logic [1:0]  resultSrcM,
  input  logic [15:0] aluResM,
  input  logic [15:0] writeDataM,
  input  logic [15:0] PCPlus2M,
  input  logic [3:0]  RdM,
  output logic        memReq,
  output logic        memWe,
  output logic [15:0] memAddr,
  output logic [15:0] memWdata,
  input  logic [15:0] memRdata,
  input  logic        memAck,
  output logic        stallM,
  output logic        busErr,
  output logic        regWriteW,
  output logic [3:0]  RdW,
  output logic [15:0] aluResW,
  output logic [15:0] readDataW,
  output logic [15:0] PCPlus2W,
  output logic [1:0]  resultSrcW,
  output logic [15:0] resultW
);

  localparam int CW = $clog2(TIMEOUT) + 1;

  typedef enum logic {IDLE, WAIT} stateT;

  stateT         state, stateNext;
  logic [CW-1:0] count;
  logic          access, isLoad, ackNow, timeoutNow;
  logic          startAcc, finishWb;
  logic [15:0]   readDataNext;

  // A store tagged as a load is still only a store.
  assign access     = memWriteM | (resultSrcM == 2'b01);
  assign isLoad     = ~memWriteM & (resultSrcM == 2'b01);
  assign ackNow     = (state == WAIT) & memAck;
  // An ack arriving on the last allowed cycle takes precedence over the timeout.
  assign timeoutNow = (state == WAIT) & ~memAck & (count == CW'(TIMEOUT - 1));

  // Next-state logic and stage control: finishWb means the instruction leaves MEM this cycle.
  always_comb begin
    stateNext = state;
    startAcc  = 1'b0;
    finishWb  = 1'b0;
    stallM    = 1'b0;
    case (state)
      IDLE: begin
        if (access) begin
          startAcc  = 1'b1;
          stallM    = 1'b1;
          stateNext = WAIT;
        end else begin
          finishWb = 1'b1;
        end
      end
      WAIT: begin
        if (ackNow || timeoutNow) begin
          finishWb  = 1'b1;
          stateNext = IDLE;
        end else begin
          stallM = 1'b1;
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= stateNext;
  end

  // Bus request registers, wait counter and sticky error; address/data are captured once per access.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      memReq   <= 1'b0;
      memWe    <= 1'b0;
      memAddr  <= '0;
      memWdata <= '0;
      count    <= '0;
      busErr   <= 1'b0;
    end else begin
      if (startAcc) begin
        memReq   <= 1'b1;
        memWe    <= memWriteM;
        memAddr  <= aluResM;
        memWdata <= writeDataM;
        count    <= '0;
      end else if (state == WAIT) begin
        if (ackNow || timeoutNow) memReq <= 1'b0;
        else                      count  <= count + CW'(1);
      end
      if (timeoutNow) busErr <= 1'b1;
    end
  end

  // Load data captured into MEM/WB: bus data on a load ack, error pattern on timeout, else zero.
  always_comb begin
    readDataNext = '0;
    if (timeoutNow)            readDataNext = ERR_DATA;
    else if (ackNow && isLoad) readDataNext = memRdata;
  end

  // MEM/WB register: takes the finishing instruction, otherwise a bubble.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      regWriteW  <= 1'b0;
      RdW        <= '0;
      aluResW    <= '0;
      readDataW  <= '0;
      PCPlus2W   <= '0;
      resultSrcW <= '0;
    end else if (finishWb) begin
      regWriteW  <= regWriteM;
      RdW        <= RdM;
      aluResW    <= aluResM;
      readDataW  <= readDataNext;
      PCPlus2W   <= PCPlus2M;
      resultSrcW <= resultSrcM;
    end else begin
      regWriteW  <= 1'b0;
      RdW        <= '0;
      aluResW    <= '0;
      readDataW  <= '0;
      PCPlus2W   <= '0;
      resultSrcW <= '0;
    end
  end

  // Write-back result select; the reserved encoding falls back to the ALU result.
  always_comb begin
    case (resultSrcW)
      2'b01:   resultW = readDataW;
      2'b10:   resultW = PCPlus2W;
      default: resultW = aluResW;
    endcase
  end

endmodule

// File: tb/tb_memory_stage.sv
// tb/tb_memory_stage.sv - randomized transaction-level bench for memory_stage
module tb_memory_stage;

  localparam int          TIMEOUT  = 16;
  localparam logic [15:0] ERR_DATA = 16'hDEAD;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        regWriteM, memWriteM;
  logic [1:0]  resultSrcM;
  logic [15:0] aluResM, writeDataM, PCPlus2M;
  logic [3:0]  RdM;
  logic        memReq, memWe;
  logic [15:0] memAddr, memWdata;
  logic [15:0] memRdata;
  logic        memAck;
  logic        stallM, busErr, regWriteW;
  logic [3:0]  RdW;
  logic [15:0] aluResW, readDataW, PCPlus2W, resultW;
  logic [1:0]  resultSrcW;

  memory_stage #(.TIMEOUT(TIMEOUT), .ERR_DATA(ERR_DATA)) dut (
    .clk(clk), .rst(rst),
    .regWriteM(regWriteM), .memWriteM(memWriteM), .resultSrcM(resultSrcM),
    .aluResM(aluResM), .writeDataM(writeDataM), .PCPlus2M(PCPlus2M), .RdM(RdM),
    .memReq(memReq), .memWe(memWe), .memAddr(memAddr), .memWdata(memWdata),
    .memRdata(memRdata), .memAck(memAck),
    .stallM(stallM), .busErr(busErr),
    .regWriteW(regWriteW), .RdW(RdW), .aluResW(aluResW), .readDataW(readDataW),
    .PCPlus2W(PCPlus2W), .resultSrcW(resultSrcW), .resultW(resultW)
  );

  always #5 clk = ~clk;

  int   testsRun    = 0;
  int   testsFailed = 0;
  logic expErr      = 1'b0;

  task automatic checkEq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    testsRun++;
    if (got !== exp) begin
      testsFailed++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic driveM(input logic rw, input logic mw, input logic [1:0] src,
                        input logic [15:0] alu, input logic [15:0] wd,
                        input logic [15:0] pc, input logic [3:0] rd);
    regWriteM  = rw;
    memWriteM  = mw;
    resultSrcM = src;
    aluResM    = alu;
    writeDataM = wd;
    PCPlus2M   = pc;
    RdM        = rd;
  endtask

  // One instruction through MEM. ackDelay = WAIT cycles without ack before the ack;
  // ackDelay >= TIMEOUT means the slave never answers.
  task automatic runInstr(input logic rw, input logic mw, input logic [1:0] src,
                          input logic [15:0] alu, input logic [15:0] wd,
                          input logic [15:0] pc, input logic [3:0] rd,
                          input int ackDelay);
    logic        acc, ld, timedOut, done;
    logic [15:0] rdata, expRead, expResult;
    int          expReq, waitSeen, stallSeen;
    acc       = mw || (src == 2'b01);
    ld        = !mw && (src == 2'b01);
    timedOut  = acc && (ackDelay >= TIMEOUT);
    rdata     = 16'($urandom);
    expReq    = !acc ? 0 : (timedOut ? TIMEOUT : ackDelay + 1);
    waitSeen  = 0;
    stallSeen = 0;
    done      = 1'b0;
    driveM(rw, mw, src, alu, wd, pc, rd);
    for (int cyc = 0; cyc < TIMEOUT + 8 && !done; cyc++) begin
      if (memReq) begin
        memAck   = (waitSeen == ackDelay);
        memRdata = memAck ? rdata : 16'($urandom);
      end else begin
        memAck   = 1'($urandom_range(0, 1));
        memRdata = 16'($urandom);
      end
      @(negedge clk);
      if (memReq) begin
        waitSeen++;
        checkEq("memAddr", memAddr, alu);
        checkEq("memWe", memWe, mw);
        checkEq("memWdata", memWdata, wd);
      end
      if (cyc > 0)
        checkEq("bubble", {regWriteW, RdW, resultSrcW, aluResW, readDataW, PCPlus2W}, 0);
      if (stallM) stallSeen++;
      else        done = 1'b1;
      @(posedge clk);
      #1;
    end
    memAck = 1'b0;
    if (!done) checkEq("stallBound", 0, 1);
    checkEq("stallCycles", stallSeen, expReq);
    checkEq("reqCycles", waitSeen, expReq);
    if (timedOut) expErr = 1'b1;
    if (!acc)          expRead = 16'h0;
    else if (timedOut) expRead = ERR_DATA;
    else if (ld)       expRead = rdata;
    else               expRead = 16'h0;
    case (src)
      2'b01:   expResult = expRead;
      2'b10:   expResult = pc;
      default: expResult = alu;
    endcase
    checkEq("regWriteW", regWriteW, rw);
    checkEq("RdW", RdW, rd);
    checkEq("resultSrcW", resultSrcW, src);
    checkEq("aluResW", aluResW, alu);
    checkEq("readDataW", readDataW, expRead);
    checkEq("PCPlus2W", PCPlus2W, pc);
    checkEq("resultW", resultW, expResult);
    checkEq("busErr", busErr, expErr);
    checkEq("memReqDone", memReq, 0);
  endtask

  initial begin
    memAck   = 1'b0;
    memRdata = 16'($urandom);
    driveM(1'($urandom), 1'($urandom), 2'($urandom), 16'($urandom), 16'($urandom),
           16'($urandom), 4'($urandom));

    // Reset with random inputs.
    repeat (2) @(posedge clk);
    #1;
    checkEq("rstBus", {memReq, memWe, memAddr, memWdata, busErr}, 0);
    checkEq("rstWb", {regWriteW, RdW, resultSrcW, aluResW, readDataW, PCPlus2W}, 0);
    checkEq("rstResult", resultW, 0);
    driveM(0, 0, 2'b00, 0, 0, 0, 0);
    rst = 1'b1;
    @(negedge clk);
    checkEq("rstStall", stallM, 0);
    checkEq("rstReq", memReq, 0);
    @(posedge clk);
    #1;

    // Directed cases.
    runInstr(1, 0, 2'b00, 16'h1234, 16'($urandom), 16'($urandom), 4'h3, 0);
    runInstr(1, 0, 2'b01, 16'h0040, 16'($urandom), 16'($urandom), 4'h5, 2);
    runInstr(0, 1, 2'b00, 16'h0010, 16'hA5A5, 16'($urandom), 4'h0, 0);
    runInstr(1, 0, 2'b10, 16'($urandom), 16'($urandom), 16'h0022, 4'h7, 0);
    runInstr(1, 1, 2'b01, 16'h0080, 16'h5A5A, 16'($urandom), 4'h2, 1);
    runInstr(1, 0, 2'b01, 16'h00C0, 16'($urandom), 16'($urandom), 4'h9, TIMEOUT - 1);
    checkEq("ackAtLimitNoErr", busErr, 0);

    // Randomized mix.
    for (int n = 0; n < 40; n++) begin
      int sel, delay;
      sel = $urandom_range(0, 9);
      if (sel == 0)      delay = TIMEOUT;
      else if (sel == 1) delay = TIMEOUT - 1;
      else               delay = $urandom_range(0, 4);
      runInstr(1'($urandom), ($urandom_range(0, 3) == 0), 2'($urandom), 16'($urandom),
               16'($urandom), 16'($urandom), 4'($urandom), delay);
    end

    // Forced timeout, error stays set afterwards.
    runInstr(1, 0, 2'b01, 16'h0100, 16'($urandom), 16'($urandom), 4'hA, TIMEOUT + 4);
    runInstr(1, 0, 2'b00, 16'h4321, 16'($urandom), 16'($urandom), 4'h1, 0);
    checkEq("busErrSticky", busErr, 1);

    // Reset while a load is outstanding.
    driveM(1, 0, 2'b01, 16'h0200, 16'h0, 16'h0, 4'hB);
    memAck = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkEq("waitReq", memReq, 1);
    #2;
    rst = 1'b0;
    #1;
    checkEq("rstWaitReq", memReq, 0);
    checkEq("rstWaitErr", busErr, 0);
    checkEq("rstWaitWb", {regWriteW, resultW}, 0);
    driveM(0, 0, 2'b00, 0, 0, 0, 0);
    #1;
    checkEq("rstWaitIdle", stallM, 0);
    expErr = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    runInstr(1, 0, 2'b11, 16'h0F0F, 16'($urandom), 16'($urandom), 4'hC, 0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
